// File: rtl/ex_stage.sv
// MIPS execute stage with forwarding, ALU and the EX/MEM pipeline register.
// Define EX_MUL_EN to build the iterative shift-add multiplier for ALUOp 11 (stalls via EX_Busy).
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_RegWrite,
  input  logic        EX_MemtoReg,
  input  logic        EX_MemWrite,
  input  logic        EX_ALUSrc,
  input  logic        EX_RegDst,
  input  logic [3:0]  EX_ALUOp,
  input  logic [31:0] EX_rsData,
  input  logic [31:0] EX_rtData,
  input  logic [31:0] EX_ExtImm,
  input  logic [4:0]  EX_rtAddr,
  input  logic [4:0]  EX_rdAddr,
  input  logic [4:0]  EX_Shamt,
  input  logic [1:0]  ForwardA,
  input  logic [1:0]  ForwardB,
  input  logic [31:0] MEM_FwdData,
  input  logic [31:0] WB_FwdData,
  output logic        MEM_RegWrite,
  output logic        MEM_MemtoReg,
  output logic        MEM_MemWrite,
  output logic [31:0] MEM_ALUOut,
  output logic [31:0] MEM_WriteData,
  output logic [4:0]  MEM_WriteAddr,
  output logic        EX_Busy
);

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpXor = 4'd4;
  localparam logic [3:0] OpNor = 4'd5;
  localparam logic [3:0] OpSlt = 4'd6;
  localparam logic [3:0] OpSll = 4'd7;
  localparam logic [3:0] OpSrl = 4'd8;
  localparam logic [3:0] OpSra = 4'd9;
  localparam logic [3:0] OpLui = 4'd10;

  logic [31:0] w_fwd_a;
  logic [31:0] w_fwd_b;
  logic [31:0] w_src_b;
  logic [31:0] w_alu_result;
  logic [4:0]  w_dest;

  logic        r_mem_regwrite;
  logic        r_mem_memtoreg;
  logic        r_mem_memwrite;
  logic [31:0] r_mem_aluout;
  logic [31:0] r_mem_writedata;
  logic [4:0]  r_mem_writeaddr;

  // Select 2'b11 deliberately falls back to the register-file value.
  always_comb begin
    case (ForwardA)
      2'b01:   w_fwd_a = WB_FwdData;
      2'b10:   w_fwd_a = MEM_FwdData;
      default: w_fwd_a = EX_rsData;
    endcase
    case (ForwardB)
      2'b01:   w_fwd_b = WB_FwdData;
      2'b10:   w_fwd_b = MEM_FwdData;
      default: w_fwd_b = EX_rtData;
    endcase
  end

  assign w_src_b = EX_ALUSrc ? EX_ExtImm : w_fwd_b;
  assign w_dest  = EX_RegDst ? EX_rdAddr : EX_rtAddr;

  // MUL (11) and 12-15 yield 0 here; the product comes from the multiplier path.
  always_comb begin
    w_alu_result = 32'h0;
    case (EX_ALUOp)
      OpAdd:   w_alu_result = w_fwd_a + w_src_b;
      OpSub:   w_alu_result = w_fwd_a - w_src_b;
      OpAnd:   w_alu_result = w_fwd_a & w_src_b;
      OpOr:    w_alu_result = w_fwd_a | w_src_b;
      OpXor:   w_alu_result = w_fwd_a ^ w_src_b;
      OpNor:   w_alu_result = ~(w_fwd_a | w_src_b);
      OpSlt:   w_alu_result = {31'h0, $signed(w_fwd_a) < $signed(w_src_b)};
      OpSll:   w_alu_result = w_src_b << EX_Shamt;
      OpSrl:   w_alu_result = w_src_b >> EX_Shamt;
      OpSra:   w_alu_result = $signed(w_src_b) >>> EX_Shamt;
      OpLui:   w_alu_result = {w_src_b[15:0], 16'h0};
      default: w_alu_result = 32'h0;
    endcase
  end

`ifdef EX_MUL_EN
  localparam logic [3:0] OpMul = 4'd11;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} mul_state_e;

  mul_state_e  r_state;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_acc;
  logic [4:0]  r_count;
  logic        w_is_mul;

  assign w_is_mul = (EX_ALUOp == OpMul);
  // Gated by rst so an aborted multiply never reports a stall while reset is held.
  assign EX_Busy  = ~rst & ((r_state == StBusy) | ((r_state == StIdle) & w_is_mul));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= StIdle;
      r_mcand         <= 32'h0;
      r_mplier        <= 32'h0;
      r_acc           <= 32'h0;
      r_count         <= 5'h0;
      r_mem_regwrite  <= 1'b0;
      r_mem_memtoreg  <= 1'b0;
      r_mem_memwrite  <= 1'b0;
      r_mem_aluout    <= 32'h0;
      r_mem_writedata <= 32'h0;
      r_mem_writeaddr <= 5'h0;
    end else begin
      r_mem_regwrite  <= 1'b0;
      r_mem_memtoreg  <= 1'b0;
      r_mem_memwrite  <= 1'b0;
      r_mem_aluout    <= 32'h0;
      r_mem_writedata <= 32'h0;
      r_mem_writeaddr <= 5'h0;
      unique case (r_state)
        StIdle: begin
          if (w_is_mul) begin
            r_mcand  <= w_fwd_a;
            r_mplier <= w_src_b;
            r_acc    <= 32'h0;
            r_count  <= 5'h0;
            r_state  <= StBusy;
          end else begin
            r_mem_regwrite  <= EX_RegWrite;
            r_mem_memtoreg  <= EX_MemtoReg;
            r_mem_memwrite  <= EX_MemWrite;
            r_mem_aluout    <= w_alu_result;
            r_mem_writedata <= w_fwd_b;
            r_mem_writeaddr <= w_dest;
          end
        end
        StBusy: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 5'd1;
          if (r_count == 5'd31) r_state <= StDone;
        end
        StDone: begin
          r_mem_regwrite  <= EX_RegWrite;
          r_mem_memtoreg  <= EX_MemtoReg;
          r_mem_memwrite  <= EX_MemWrite;
          r_mem_aluout    <= r_acc;
          r_mem_writedata <= w_fwd_b;
          r_mem_writeaddr <= w_dest;
          r_state         <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end
`else
  assign EX_Busy = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_regwrite  <= 1'b0;
      r_mem_memtoreg  <= 1'b0;
      r_mem_memwrite  <= 1'b0;
      r_mem_aluout    <= 32'h0;
      r_mem_writedata <= 32'h0;
      r_mem_writeaddr <= 5'h0;
    end else begin
      r_mem_regwrite  <= EX_RegWrite;
      r_mem_memtoreg  <= EX_MemtoReg;
      r_mem_memwrite  <= EX_MemWrite;
      r_mem_aluout    <= w_alu_result;
      r_mem_writedata <= w_fwd_b;
      r_mem_writeaddr <= w_dest;
    end
  end
`endif

  assign MEM_RegWrite  = r_mem_regwrite;
  assign MEM_MemtoReg  = r_mem_memtoreg;
  assign MEM_MemWrite  = r_mem_memwrite;
  assign MEM_ALUOut    = r_mem_aluout;
  assign MEM_WriteData = r_mem_writedata;
  assign MEM_WriteAddr = r_mem_writeaddr;

endmodule
